// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the multi-master bus arbiter.
package bus_arbiter_pkg;

  // Arbiter FSM: ARB picks a winner, BUSY holds the grant for one transaction.
  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Bit offset of element idx inside a packed per-master vector.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner chooser. Fixed priority is a round-robin search that
// always starts from master 0, so both modes share one scan loop.
module bus_arb_pick #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  input  logic                   mode,
  output logic [NUM_MASTERS-1:0] onehot,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  // Starting from NUM_MASTERS-1 makes the search begin at index 0.
  assign start = mode ? last : IDX_W'(NUM_MASTERS - 1);

  // Scan start+1 upward with wrap; the first requesting master wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = IDX_W'((int'(start) + off) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master bus arbiter: holds each grant for a whole transaction, supports
// locked sequences and forces an error completion on unresponsive slaves.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [NUM_MASTERS-1:0]            i_m_cs,
  input  logic [NUM_MASTERS-1:0]            i_m_we,
  input  logic [NUM_MASTERS-1:0]            i_m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_dat,
  output logic [NUM_MASTERS-1:0]            o_m_ack,
  output logic [NUM_MASTERS-1:0]            o_m_err,
  output logic [NUM_MASTERS-1:0]            o_m_grant,
  output logic [ADDR_WIDTH-1:0]             o_addr,
  output logic [DATA_WIDTH-1:0]             o_dat,
  output logic                              o_we,
  output logic                              o_cs,
  input  logic                              i_ack
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant, grant_n;
  logic [IDX_W-1:0]       gidx, gidx_n;
  logic [IDX_W-1:0]       last, last_n;
  logic [CNT_W-1:0]       cnt, cnt_n;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic busy, cs_g, we_g, lock_g, timeout_hit, ack_fire, err_fire;

  bus_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req    (i_m_cs),
    .last   (last),
    .mode   (MODE == MODE_RR),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Everything the bus sees is selected by the registered grant index only.
  assign busy        = (state == BUSY);
  assign cs_g        = i_m_cs[gidx];
  assign we_g        = i_m_we[gidx];
  assign lock_g      = i_m_lock[gidx];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign ack_fire    = busy & cs_g & (i_ack | timeout_hit);
  assign err_fire    = busy & cs_g & ~i_ack & timeout_hit;

  assign o_cs      = busy & cs_g;
  assign o_we      = busy & we_g;
  assign o_addr    = busy ? i_m_addr[slice_lsb(32'(gidx), ADDR_WIDTH) +: ADDR_WIDTH] : '0;
  assign o_dat     = busy ? i_m_dat[slice_lsb(32'(gidx), DATA_WIDTH) +: DATA_WIDTH] : '0;
  assign o_m_ack   = ack_fire ? grant : '0;
  assign o_m_err   = err_fire ? grant : '0;
  assign o_m_grant = grant;

  // State, grant, round-robin pointer and timeout counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ARB;
      grant <= '0;
      gidx  <= '0;
      last  <= IDX_W'(NUM_MASTERS - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      gidx  <= gidx_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: grant in ARB; in BUSY finish on ack, abandon or timeout.
  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx_n  = gidx;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      ARB: begin
        cnt_n = '0;
        if (pick_valid) begin
          state_n = BUSY;
          grant_n = pick_onehot;
          gidx_n  = pick_idx;
          last_n  = pick_idx;
        end
      end
      BUSY: begin
        if (!cs_g) begin
          state_n = ARB;
          grant_n = '0;
          cnt_n   = '0;
        end else if (i_ack) begin
          cnt_n = '0;
          if (!lock_g) begin
            state_n = ARB;
            grant_n = '0;
          end
        end else if (timeout_hit) begin
          state_n = ARB;
          grant_n = '0;
          cnt_n   = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ARB;
        grant_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: a fixed-priority instance (timeout 4) and a round-robin
// instance (timeout disabled) share the same master stimulus.
module tb_bus_arbiter;

  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        we;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  m_cs, m_we, m_lock;
  logic [47:0] m_addr;
  logic [23:0] m_dat;
  logic        ack_in;

  logic [2:0]  f_ack, f_err, f_grant, r_ack, r_err, r_grant;
  logic [15:0] f_addr, r_addr;
  logic [7:0]  f_dat, r_dat;
  logic        f_we, f_cs, r_we, r_cs;

  int   tests = 0;
  int   fails = 0;
  logic sel   = 1'b0;
  exp_t sb[$];

  logic [2:0]  mon_ack, mon_err;
  logic [15:0] mon_addr;
  logic [7:0]  mon_dat;
  logic        mon_we;
  exp_t        mon_exp;

  bus_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MODE(0), .TIMEOUT_CYCLES(4)) dut_fixed (
    .i_clk(clk), .i_reset_n(reset_n), .i_m_cs(m_cs), .i_m_we(m_we), .i_m_lock(m_lock),
    .i_m_addr(m_addr), .i_m_dat(m_dat), .o_m_ack(f_ack), .o_m_err(f_err), .o_m_grant(f_grant),
    .o_addr(f_addr), .o_dat(f_dat), .o_we(f_we), .o_cs(f_cs), .i_ack(ack_in)
  );

  bus_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MODE(1), .TIMEOUT_CYCLES(0)) dut_rr (
    .i_clk(clk), .i_reset_n(reset_n), .i_m_cs(m_cs), .i_m_we(m_we), .i_m_lock(m_lock),
    .i_m_addr(m_addr), .i_m_dat(m_dat), .o_m_ack(r_ack), .o_m_err(r_err), .o_m_grant(r_grant),
    .o_addr(r_addr), .o_dat(r_dat), .o_we(r_we), .o_cs(r_cs), .i_ack(ack_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every ack/err pulse from the selected instance must match the next expected transfer.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      mon_ack  = sel ? r_ack  : f_ack;
      mon_err  = sel ? r_err  : f_err;
      mon_addr = sel ? r_addr : f_addr;
      mon_dat  = sel ? r_dat  : f_dat;
      mon_we   = sel ? r_we   : f_we;
      if (mon_ack != 3'b000 || mon_err != 3'b000) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_ack t=%0t got ack=%b err=%b expected none", $time, mon_ack, mon_err);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_ack !== mon_exp.ack || mon_err !== mon_exp.err || mon_addr !== mon_exp.addr ||
              mon_dat !== mon_exp.dat || mon_we !== mon_exp.we) begin
            fails++;
            $display("[TB] FAIL scoreboard t=%0t got ack=%b err=%b addr=%h dat=%h we=%b expected ack=%b err=%b addr=%h dat=%h we=%b",
                     $time, mon_ack, mon_err, mon_addr, mon_dat, mon_we,
                     mon_exp.ack, mon_exp.err, mon_exp.addr, mon_exp.dat, mon_exp.we);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] g, input logic err, input logic [15:0] a,
                          input logic [7:0] d, input logic w);
    exp_t e;
    e.ack  = g;
    e.err  = err ? g : 3'b000;
    e.addr = a;
    e.dat  = d;
    e.we   = w;
    sb.push_back(e);
  endtask

  task automatic set_master(input int k, input logic cs, input logic we, input logic lock,
                            input logic [15:0] a, input logic [7:0] d);
    m_cs[k]          = cs;
    m_we[k]          = we;
    m_lock[k]        = lock;
    m_addr[k*16 +: 16] = a;
    m_dat[k*8 +: 8]    = d;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    m_cs    = '0;
    m_we    = '0;
    m_lock  = '0;
    ack_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    m_cs = 3'b111; m_we = 3'b111; m_lock = '0; m_addr = 48'hAAAA_BBBB_CCCC; m_dat = 24'h112233;
    ack_in = 1'b1;
    @(posedge clk);
    sample;
    tests++; if (f_grant !== 3'b000) begin fails++; $display("[TB] FAIL reset_f_grant got %b expected 000", f_grant); end
    tests++; if (f_cs !== 1'b0 || f_addr !== 16'h0) begin fails++; $display("[TB] FAIL reset_f_bus got cs=%b addr=%h expected 0/0000", f_cs, f_addr); end
    tests++; if (f_ack !== 3'b000) begin fails++; $display("[TB] FAIL reset_f_ack got %b expected 000", f_ack); end
    tests++; if (r_grant !== 3'b000 || r_cs !== 1'b0) begin fails++; $display("[TB] FAIL reset_r_grant got grant=%b cs=%b expected 000/0", r_grant, r_cs); end
    tests++; if (r_ack !== 3'b000 || r_err !== 3'b000) begin fails++; $display("[TB] FAIL reset_r_ack got ack=%b err=%b expected 000/000", r_ack, r_err); end
    do_reset;
  endtask

  task automatic test_fixed_priority;
    do_reset; sel = 1'b0; tick;
    set_master(1, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h11);
    set_master(2, 1'b1, 1'b0, 1'b0, 16'h2222, 8'h22);
    tick; sample;
    tests++; if (f_grant !== 3'b010) begin fails++; $display("[TB] FAIL fixed_grant got %b expected 010", f_grant); end
    tests++; if (f_cs !== 1'b1 || f_addr !== 16'h1234 || f_dat !== 8'h11 || f_we !== 1'b1) begin
      fails++; $display("[TB] FAIL fixed_bus got cs=%b addr=%h dat=%h we=%b expected 1/1234/11/1", f_cs, f_addr, f_dat, f_we);
    end
    tick; ack_in = 1'b1; push_exp(3'b010, 1'b0, 16'h1234, 8'h11, 1'b1);
    sample;
    tick; m_cs[1] = 1'b0; ack_in = 1'b0; sample;
    tests++; if (f_grant !== 3'b000 || f_cs !== 1'b0 || f_addr !== 16'h0) begin
      fails++; $display("[TB] FAIL fixed_arb_idle got grant=%b cs=%b addr=%h expected 000/0/0000", f_grant, f_cs, f_addr);
    end
    tick; sample;
    tests++; if (f_grant !== 3'b100 || f_addr !== 16'h2222 || f_we !== 1'b0) begin
      fails++; $display("[TB] FAIL fixed_second got grant=%b addr=%h we=%b expected 100/2222/0", f_grant, f_addr, f_we);
    end
    tick; ack_in = 1'b1; push_exp(3'b100, 1'b0, 16'h2222, 8'h22, 1'b0); sample;
    tick; m_cs = '0; ack_in = 1'b0; sample;
    tests++; if (f_grant !== 3'b000) begin fails++; $display("[TB] FAIL fixed_release got %b expected 000", f_grant); end
  endtask

  task automatic test_round_robin;
    int mi;
    do_reset; sel = 1'b1; tick;
    for (int k = 0; k < 3; k++)
      set_master(k, 1'b1, k[0], 1'b0, 16'h1000 + 16'(k), 8'h10 + 8'(k));
    ack_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mi = i % 3;
      tick;
      push_exp(3'(1 << mi), 1'b0, 16'h1000 + 16'(mi), 8'h10 + 8'(mi), mi[0]);
      sample;
      tests++; if (r_grant !== 3'(1 << mi)) begin fails++; $display("[TB] FAIL rr_grant_%0d got %b expected %b", i, r_grant, 3'(1 << mi)); end
      tick; sample;
      tests++; if (r_grant !== 3'b000) begin fails++; $display("[TB] FAIL rr_arb_gap_%0d got %b expected 000", i, r_grant); end
    end
    m_cs = '0; ack_in = 1'b0;
  endtask

  task automatic test_lock;
    do_reset; sel = 1'b0; tick;
    set_master(0, 1'b1, 1'b1, 1'b1, 16'h8000, 8'h55);
    set_master(1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'h77);
    tick; ack_in = 1'b1; push_exp(3'b001, 1'b0, 16'h8000, 8'h55, 1'b1); sample;
    tests++; if (f_grant !== 3'b001 || f_addr !== 16'h8000) begin
      fails++; $display("[TB] FAIL lock_first got grant=%b addr=%h expected 001/8000", f_grant, f_addr);
    end
    tick; set_master(0, 1'b1, 1'b1, 1'b0, 16'h8001, 8'hAA); push_exp(3'b001, 1'b0, 16'h8001, 8'hAA, 1'b1); sample;
    tests++; if (f_grant !== 3'b001 || f_cs !== 1'b1 || f_addr !== 16'h8001) begin
      fails++; $display("[TB] FAIL lock_held got grant=%b cs=%b addr=%h expected 001/1/8001", f_grant, f_cs, f_addr);
    end
    tick; m_cs[0] = 1'b0; ack_in = 1'b0; sample;
    tests++; if (f_grant !== 3'b000) begin fails++; $display("[TB] FAIL lock_release got %b expected 000", f_grant); end
    tick; ack_in = 1'b1; push_exp(3'b010, 1'b0, 16'h4000, 8'h77, 1'b0); sample;
    tests++; if (f_grant !== 3'b010) begin fails++; $display("[TB] FAIL lock_next_master got %b expected 010", f_grant); end
    tick; m_cs = '0; ack_in = 1'b0; sample;
  endtask

  task automatic test_timeout;
    do_reset; sel = 1'b0; tick;
    set_master(2, 1'b1, 1'b1, 1'b0, 16'h3333, 8'h33);
    tick; sample;
    tests++; if (f_grant !== 3'b100) begin fails++; $display("[TB] FAIL timeout_grant got %b expected 100", f_grant); end
    tick; tick; tick;
    push_exp(3'b100, 1'b1, 16'h3333, 8'h33, 1'b1); sample;
    tests++; if (f_err !== 3'b100) begin fails++; $display("[TB] FAIL timeout_err got %b expected 100", f_err); end
    tests++; if (r_ack !== 3'b000 || r_err !== 3'b000) begin
      fails++; $display("[TB] FAIL timeout_disabled got ack=%b err=%b expected 000/000", r_ack, r_err);
    end
    tick; m_cs[2] = 1'b0; sample;
    tests++; if (f_grant !== 3'b000) begin fails++; $display("[TB] FAIL timeout_to_arb got %b expected 000", f_grant); end
    tests++; if (r_grant !== 3'b100) begin fails++; $display("[TB] FAIL timeout_disabled_hold got %b expected 100", r_grant); end
    tick;
    set_master(2, 1'b1, 1'b1, 1'b0, 16'h3333, 8'h33);
    tick; tick; tick; tick;
    ack_in = 1'b1; push_exp(3'b100, 1'b0, 16'h3333, 8'h33, 1'b1); sample;
    tests++; if (f_err !== 3'b000 || f_ack !== 3'b100) begin
      fails++; $display("[TB] FAIL timeout_ack_wins got ack=%b err=%b expected 100/000", f_ack, f_err);
    end
    tick; m_cs = '0; ack_in = 1'b0; sample;
    tests++; if (f_grant !== 3'b000) begin fails++; $display("[TB] FAIL timeout_ack_release got %b expected 000", f_grant); end
  endtask

  task automatic test_abandon_reset;
    do_reset; sel = 1'b1; tick;
    set_master(1, 1'b1, 1'b0, 1'b0, 16'h5555, 8'h5A);
    tick; sample;
    tests++; if (r_grant !== 3'b010 || r_addr !== 16'h5555) begin
      fails++; $display("[TB] FAIL abandon_grant got grant=%b addr=%h expected 010/5555", r_grant, r_addr);
    end
    tick; m_cs[1] = 1'b0; sample;
    tests++; if (r_cs !== 1'b0 || r_ack !== 3'b000 || r_grant !== 3'b010) begin
      fails++; $display("[TB] FAIL abandon_drop got cs=%b ack=%b grant=%b expected 0/000/010", r_cs, r_ack, r_grant);
    end
    tick; sample;
    tests++; if (r_grant !== 3'b000) begin fails++; $display("[TB] FAIL abandon_to_arb got %b expected 000", r_grant); end
    set_master(0, 1'b1, 1'b1, 1'b0, 16'h6000, 8'h60);
    set_master(1, 1'b1, 1'b1, 1'b0, 16'h6001, 8'h61);
    set_master(2, 1'b1, 1'b1, 1'b0, 16'h6002, 8'h62);
    tick; sample;
    tests++; if (r_grant !== 3'b100) begin fails++; $display("[TB] FAIL rr_after_abandon got %b expected 100", r_grant); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (r_cs !== 1'b0 || r_grant !== 3'b000 || f_cs !== 1'b0 || f_grant !== 3'b000) begin
      fails++; $display("[TB] FAIL async_reset got r_cs=%b r_grant=%b f_cs=%b f_grant=%b expected all 0", r_cs, r_grant, f_cs, f_grant);
    end
    ack_in = 1'b1;
    #1;
    tests++; if (r_ack !== 3'b000 || f_ack !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_no_ack got r_ack=%b f_ack=%b expected 000/000", r_ack, f_ack);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick; push_exp(3'b001, 1'b0, 16'h6000, 8'h60, 1'b1); sample;
    tests++; if (r_grant !== 3'b001) begin fails++; $display("[TB] FAIL rr_first_after_reset got %b expected 001", r_grant); end
    tick; m_cs = '0; ack_in = 1'b0; sample;
  endtask

  initial begin
    test_reset;
    test_fixed_priority;
    test_round_robin;
    test_lock;
    test_timeout;
    test_abandon_reset;
    repeat (2) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised multi-master bus arbiter for the Z80 computer's shared 8-bit memory bus. It generalises the fixed CPU/UART master mux to N masters, with selectable fixed-priority or round-robin arbitration. Each grant is held for a whole transaction, so address, data and strobes stay stable until acknowledged. Locked read-modify-write sequences and a timeout for unresponsive slaves are added. It sits between the masters (UART master, CPU, future VGA/DMA) and the memory/peripheral bus.

## Interface
- NUM_MASTERS, 3, number of masters (2..8); index 0 is highest priority in fixed mode
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 8, bus write-data width
- MODE, 0, 0 = fixed priority, 1 = round-robin
- TIMEOUT_CYCLES, 255, cycles in BUSY before forced error completion; 0 disables; counter width $clog2(TIMEOUT_CYCLES+1)
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_m_cs  in  NUM_MASTERS  per-master request; held until that master's ack
- i_m_we  in  NUM_MASTERS  per-master write enable
- i_m_lock  in  NUM_MASTERS  keep grant after this transaction's ack
- i_m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_m_dat  in  NUM_MASTERS*DATA_WIDTH  packed write data
- o_m_ack  out  NUM_MASTERS  per-master completion pulse
- o_m_err  out  NUM_MASTERS  pulses together with o_m_ack on timeout
- o_m_grant  out  NUM_MASTERS  one-hot registered grant
- o_addr  out  ADDR_WIDTH  bus address
- o_dat  out  DATA_WIDTH  bus write data
- o_we  out  1  bus write enable
- o_cs  out  1  bus chip select
- i_ack  in  1  slave acknowledge

Read data is not routed here; masters sample the shared slave data directly.

## Operation
- States: ARB and BUSY.
- ARB:
  - o_cs, o_we, o_addr and o_dat are all 0.
  - If any i_m_cs bit is set, register the winner into o_m_grant (one-hot) and go to BUSY.
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: search from last+1 upward with wrap; last is the index of the most recently granted master.
- BUSY with granted master g:
  - o_cs = i_m_cs[g]; o_we, o_addr and o_dat come from master g.
  - The mux select is the registered grant only, never the live requests.
- Completion: i_ack & i_m_cs[g] asserts o_m_ack[g] combinationally in the same cycle.
  - If i_m_lock[g] is 0: next state ARB, grant cleared.
  - If i_m_lock[g] is 1: stay BUSY with the same g and clear the timeout counter.
- Abandon: i_m_cs[g] drops with no ack → next state ARB, no ack.
- Timeout: the counter increments each BUSY cycle without ack and clears on grant or ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: pulse o_m_ack[g] and o_m_err[g], go to ARB, clear lock.
  - An ack in the timeout cycle is a normal completion (err=0).
- Requests from other masters while BUSY are ignored and must stay asserted.
- o_m_ack and o_m_err are never asserted for a non-granted master. i_ack seen in ARB is ignored.
- `last` updates only on a new grant from ARB.

## Timing
- Reset (async assert, sync release): state ARB, o_m_grant=0, last=NUM_MASTERS-1 (master 0 is first in round-robin), counter 0.
  - All outputs are 0 while in reset.
- Reset mid-transaction drops the bus immediately; no ack or err is issued.
- Grant latency: i_m_cs rising before edge t gives o_m_grant and o_cs valid after edge t. The earliest ack is in that same cycle.
- Minimum transaction spacing: 2 cycles (BUSY + ARB) for non-locked back-to-back transfers. Locked transfers can complete every cycle.
- Simultaneous requests in ARB resolve in one cycle, with no idle grant cycle.

## Structure
- Package bus_arbiter_pkg: state encoding (ARB=0, BUSY=1), MODE_FIXED=0 and MODE_RR=1, and a packed-slice helper function.
- Sub-module bus_arb_pick: combinational chooser.
  - Inputs: request vector, last index, mode.
  - Outputs: one-hot winner, winner index, valid.
- The top level holds the FSM, timeout counter, output mux and ack routing.

## Test plan
- Fixed mode, NUM_MASTERS=3: cs=3'b110 → grant 3'b010. Addr 0x1234 is driven; ack after 2 cycles → o_m_ack=3'b010. Master 2 is granted two cycles later.
- Round-robin, all three requesting continuously, ack every BUSY cycle → grant sequence 001, 010, 100, 001.
- Lock: master 0 lock=1 over two writes (0x8000/0x55, 0x8001/0xAA) while master 1 requests → master 0 gets both transfers with no ARB cycle between them, then master 1 is granted.
- Timeout, TIMEOUT_CYCLES=4: no ack → o_m_ack[g] and o_m_err[g] pulse in the 4th BUSY cycle, state returns to ARB. Ack in the 4th cycle instead gives err=0.
- Abandon plus reset: master drops cs mid-BUSY → ARB with no ack. Asserting i_reset_n=0 mid-BUSY clears o_cs and o_m_grant asynchronously, and after release master 0 wins first in round-robin.
